seq_logic_unit: RTL and testbench

- Multi-cycle, parametrised bitwise logic unit for the sequential RISC-V datapath.
- Generalises the fixed 64-bit AND to four selectable ops and any WIDTH.
- Processes CHUNK bits per cycle to trade latency for area.
- Uses valid/ready handshakes on input and output so the sequential controller can stall on either side.

---
 rtl/seq_logic_unit.sv | 138 +++++++++++++
 tb/tb_seq_logic_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multi-cycle bitwise logic unit (AND / OR / XOR / ANDN).
// Operands are latched on acceptance, then the result is built CHUNK bits per
// clock, lowest chunk first. Valid/ready handshakes are used on both sides.
//
// Optional build macro: SEQ_LOGIC_ZERO_FLAG_EN adds a `zero` output. It is
// high in DONE when the whole result is zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new operation (in_ready=1)
// BUSY  | computing chunk cnt_q each clock, lowest chunk first
// DONE  | result valid on Y (out_valid=1), waiting for out_ready
module seq_logic_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] y_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] r_chunk;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Y         = y_q;

    // Select the current chunk of each latched operand and apply the latched op.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        case (op_q)
            OP_AND:  r_chunk = a_chunk & b_chunk;
            OP_OR:   r_chunk = a_chunk | b_chunk;
            OP_XOR:  r_chunk = a_chunk ^ b_chunk;
            OP_ANDN: r_chunk = a_chunk & ~b_chunk;
            default: r_chunk = '0;
        endcase
    end

    // FSM, operand capture and chunk-by-chunk result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= op;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            y_q[i*CHUNK +: CHUNK] <= r_chunk;
                        end
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    logic [CHUNK-1:0] acc_q;

    // OR together every computed chunk so that DONE can report an all-zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (state_q == ST_IDLE && in_valid) begin
            acc_q <= '0;
        end else if (state_q == ST_BUSY) begin
            acc_q <= acc_q | r_chunk;
        end
    end

    assign zero = (state_q == ST_DONE) && (acc_q == '0);
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed testbench for seq_logic_unit: default 64/16 instance plus
// 32/32, 32/8 and 32/1 instances for the parameter sweep.
module tb_seq_logic_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    logic        zero;
    logic        s_zero [3];
`endif

    logic        s_in_valid;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic [1:0]  s_op;
    logic        s_out_ready;
    logic        s_in_ready [3];
    logic        s_out_valid [3];
    logic [31:0] s_y [3];

    int checks = 0;
    int errors = 0;

    seq_logic_unit #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .Y(y)
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    seq_logic_unit #(.WIDTH(32), .CHUNK(32)) dut_c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
        .A(s_a), .B(s_b), .op(s_op), .out_valid(s_out_valid[0]), .out_ready(s_out_ready), .Y(s_y[0])
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        , .zero(s_zero[0])
`endif
    );

    seq_logic_unit #(.WIDTH(32), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
        .A(s_a), .B(s_b), .op(s_op), .out_valid(s_out_valid[1]), .out_ready(s_out_ready), .Y(s_y[1])
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        , .zero(s_zero[1])
`endif
    );

    seq_logic_unit #(.WIDTH(32), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
        .A(s_a), .B(s_b), .op(s_op), .out_valid(s_out_valid[2]), .out_ready(s_out_ready), .Y(s_y[2])
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        , .zero(s_zero[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid is seen, bounded at 100.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [63:0] av, input logic [63:0] bv,
                          input logic [1:0] opv, output int lat);
        a        = av;
        b        = bv;
        op       = opv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = 2'b00;
        wait_done(lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (y !== 64'h0) begin
            errors++; $display("FAIL reset_y: got %h expected 0", y);
        end
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++; $display("FAIL reset_zero: got %b expected 0", zero);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_and();
        int lat;
        out_ready = 1'b1;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL and_latency: got %0d expected 4", lat);
        end
        checks++;
        if (y !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            errors++; $display("FAIL and_y: got %h expected aaaaaaaaaaaaaaaa", y);
        end
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++; $display("FAIL and_zero: got %b expected 0", zero);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL and_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_all_ops();
        logic [1:0]  ops [4];
        logic [63:0] exp [4];
        int lat;
        ops[0] = 2'b00; exp[0] = 64'h8A28_A28A_28A2_8A28;
        ops[1] = 2'b01; exp[1] = 64'hFBEF_BEFB_EFBE_FBEF;
        ops[2] = 2'b10; exp[2] = 64'h71C7_1C71_C71C_71C7;
        ops[3] = 2'b11; exp[3] = 64'h5145_1451_4514_5145;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, ops[i], lat);
            checks++;
            if (y !== exp[i] || lat != 4) begin
                errors++;
                $display("FAIL ops_%0d: got y=%h lat=%0d expected y=%h lat=4", i, y, lat, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_zero();
        int lat;
        out_ready = 1'b1;
        run_op(64'h1, 64'h0, 2'b00, lat);
        checks++;
        if (y !== 64'h0 || lat != 4) begin
            errors++; $display("FAIL zero_y: got y=%h lat=%0d expected y=0 lat=4", y, lat);
        end
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin
            errors++; $display("FAIL zero_flag: got %b expected 1", zero);
        end
`endif
        tick();
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++; $display("FAIL zero_flag_idle: got %b expected 0", zero);
        end
`endif
    endtask

    task automatic test_back_pressure();
        int lat;
        out_ready = 1'b0;
        run_op(64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, 2'b10, lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 64'h0123_4567_89AB_CDEF;
        op       = 2'b11;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (y !== 64'h71C7_1C71_C71C_71C7 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got y=%h out_valid=%b in_ready=%b expected y=71c71c71c71c71c7 out_valid=1 in_ready=0",
                         i, y, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got in_ready=%b expected 0", in_ready);
        end
        wait_done(lat);
        checks++;
        if (y !== 64'hFEDC_BA98_7654_3210 || lat != 4) begin
            errors++; $display("FAIL bp_new_op: got y=%h lat=%0d expected y=fedcba9876543210 lat=4", y, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic seen_valid;
        out_ready = 1'b1;
        a         = 64'hFFFF_FFFF_FFFF_FFFF;
        b         = 64'hFFFF_FFFF_FFFF_FFFF;
        op        = 2'b00;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_immediate: got in_ready=%b out_valid=%b y=%h expected 1/0/0", in_ready, out_valid, y);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_pulse: got out_valid pulse=%b expected 0", seen_valid);
        end
        run_op(64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, 2'b10, lat);
        checks++;
        if (y !== 64'h71C7_1C71_C71C_71C7 || lat != 4) begin
            errors++; $display("FAIL rst_mid_next_op: got y=%h lat=%0d expected y=71c71c71c71c71c7 lat=4", y, lat);
        end
        tick();
    endtask

    task automatic test_sweep();
        int lat [3];
        int exp_lat [3];
        exp_lat[0] = 1; exp_lat[1] = 4; exp_lat[2] = 32;
        for (int k = 0; k < 3; k++) lat[k] = -1;
        s_a         = 32'hF0F0_F0F0;
        s_b         = 32'h0FF0_0FF0;
        s_op        = 2'b10;
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        tick();
        s_in_valid = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (lat[k] < 0 && s_out_valid[k] === 1'b1) lat[k] = t - 1;
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            if (lat[k] < 0 && s_out_valid[k] === 1'b1) lat[k] = 40;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat[k] != exp_lat[k]) begin
                errors++; $display("FAIL sweep_latency_%0d: got %0d expected %0d", k, lat[k], exp_lat[k]);
            end
            checks++;
            if (s_y[k] !== 32'hFF00_FF00 || s_out_valid[k] !== 1'b1) begin
                errors++;
                $display("FAIL sweep_y_%0d: got y=%h out_valid=%b expected y=ff00ff00 out_valid=1", k, s_y[k], s_out_valid[k]);
            end
        end
        s_out_ready = 1'b1;
        tick();
    endtask

    initial begin
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        op          = 2'b00;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_a         = '0;
        s_b         = '0;
        s_op        = 2'b00;
        s_out_ready = 1'b0;
        test_reset();
        test_and();
        test_all_ops();
        test_zero();
        test_back_pressure();
        test_reset_mid_op();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
